// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART receiver.
//   parity_e       - parity mode selection
//   state_e        - receiver FSM states
//   ticks_per_bit  - clock cycles per bit period (integer division)
//   parity_error   - parity check for a received word
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  function automatic int ticks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  // data_xor is the XOR of all data bits, p the sampled parity bit.
  function automatic logic parity_error(input logic data_xor, input logic p, input parity_e mode);
    logic err;
    case (mode)
      PARITY_EVEN: err = data_xor ^ p;
      PARITY_ODD:  err = ~(data_xor ^ p);
      default:     err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx pad.
//   clock  - system clock
//   resetn - asynchronous active-low reset (flops reset to idle-high 1)
//   rx     - raw serial line
//   rx_s   - synchronized serial line
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic rx,
  output logic rx_s
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next-value selection for the synchronizer chain.
  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to the idle line level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (data width, parity, stop bits).
//   clock, resetn     - system clock, asynchronous active-low reset
//   enable            - 0 forces IDLE and aborts any frame in progress
//   rx                - asynchronous serial line, idle high
//   out_data/out_valid/out_ready - word delivery handshake
//   out_frame_err     - per-word: a stop bit was sampled 0
//   out_parity_err    - per-word: parity mismatch
//   overrun           - sticky: completed word dropped; overrun_clr clears it
//   break_det         - one-cycle pulse when a line break is detected
//   busy              - receiver not in IDLE
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int      CLOCK_FREQ = 50_000_000,
  parameter int      BAUD_RATE  = 115200,
  parameter int      DATA_WIDTH = 8,
  parameter parity_e PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_frame_err,
  output logic                  out_parity_err,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  break_det,
  output logic                  busy
);

  localparam int TPB   = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF  = TPB / 2;
  localparam int CNT_W = $clog2(TPB);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] TPB_M1    = CNT_W'(TPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (TPB < 4) begin : g_bad_tpb
    $error("uart_rx_cfg: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_rx_cfg: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clock  (clock),
    .resetn (resetn),
    .rx     (rx),
    .rx_s   (rx_s)
  );

  state_e                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [IDX_W-1:0]      bit_idx_d, bit_idx_q;
  logic                  stop_idx_d, stop_idx_q;
  logic [DATA_WIDTH-1:0] shift_d, shift_q;
  logic                  par_err_d, par_err_q;
  logic                  frame_acc_d, frame_acc_q;
  logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
  logic                  out_valid_d, out_valid_q;
  logic                  out_frame_err_d, out_frame_err_q;
  logic                  out_parity_err_d, out_parity_err_q;
  logic                  overrun_d, overrun_q;
  logic                  break_det_d, break_det_q;
  logic                  busy_d, busy_q;
  logic                  word_fe_s, word_brk_s;

  // Next-state, counter, shift register and output register logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bit_idx_d        = bit_idx_q;
    stop_idx_d       = stop_idx_q;
    shift_d          = shift_q;
    par_err_d        = par_err_q;
    frame_acc_d      = frame_acc_q;
    out_data_d       = out_data_q;
    out_frame_err_d  = out_frame_err_q;
    out_parity_err_d = out_parity_err_q;
    break_det_d      = 1'b0;
    word_fe_s        = frame_acc_q | ~rx_s;
    word_brk_s       = word_fe_s & (shift_q == {DATA_WIDTH{1'b0}}) & ~rx_s;

    // Consumer side; a word completing below overrides these.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = HALF_M1;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - 1'b1;
          end else if (rx_s) begin
            state_d = IDLE;          // glitch: line back high at mid start bit
          end else begin
            state_d   = DATA;
            cnt_d     = TPB_M1;
            bit_idx_d = {IDX_W{1'b0}};
          end
        end
        DATA: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            shift_d[bit_idx_q] = rx_s;
            cnt_d              = TPB_M1;
            if (bit_idx_q == LAST_IDX) begin
              stop_idx_d  = 1'b0;
              frame_acc_d = 1'b0;
              par_err_d   = 1'b0;
              if (PARITY == PARITY_NONE) begin
                state_d = STOP;
              end else begin
                state_d = uart_pkg::PARITY;
              end
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            par_err_d = parity_error(^shift_q, rx_s, PARITY);
            cnt_d     = TPB_M1;
            state_d   = STOP;
          end
        end
        STOP: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - 1'b1;
          end else if (stop_idx_q != STOP_LAST) begin
            frame_acc_d = word_fe_s;
            stop_idx_d  = stop_idx_q + 1'b1;
            cnt_d       = TPB_M1;
          end else begin
            // Last stop sample: deliver the word or flag the drop.
            if (!out_valid_q || out_ready) begin
              out_data_d       = shift_q;
              out_frame_err_d  = word_fe_s;
              out_parity_err_d = par_err_q;
              out_valid_d      = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            break_det_d = word_brk_s;
            if (word_brk_s) begin
              state_d = WAIT_HIGH;
            end else begin
              state_d = IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      cnt_q            <= CNT_ZERO;
      bit_idx_q        <= {IDX_W{1'b0}};
      stop_idx_q       <= 1'b0;
      shift_q          <= {DATA_WIDTH{1'b0}};
      par_err_q        <= 1'b0;
      frame_acc_q      <= 1'b0;
      out_data_q       <= {DATA_WIDTH{1'b0}};
      out_valid_q      <= 1'b0;
      out_frame_err_q  <= 1'b0;
      out_parity_err_q <= 1'b0;
      overrun_q        <= 1'b0;
      break_det_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_idx_q        <= bit_idx_d;
      stop_idx_q       <= stop_idx_d;
      shift_q          <= shift_d;
      par_err_q        <= par_err_d;
      frame_acc_q      <= frame_acc_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
      out_frame_err_q  <= out_frame_err_d;
      out_parity_err_q <= out_parity_err_d;
      overrun_q        <= overrun_d;
      break_det_q      <= break_det_d;
      busy_q           <= busy_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_frame_err  = out_frame_err_q;
  assign out_parity_err = out_parity_err_q;
  assign overrun        = overrun_q;
  assign break_det      = break_det_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg.
// dut_a: 8 data bits, even parity, 1 stop bit. dut_b: 7 data bits, no parity, 2 stop bits.
// Both run at TPB = 1600/100 = 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int TPB = 16;

  logic clock = 1'b0;
  logic resetn, enable;
  logic rx_a, ready_a, clr_a;
  logic rx_b, ready_b, clr_b;

  logic [7:0] data_a;
  logic       valid_a, fe_a, pe_a, ovr_a, brk_a, busy_a;
  logic [6:0] data_b;
  logic       valid_b, fe_b, pe_b, ovr_b, brk_b, busy_b;

  uart_rx_cfg #(
    .CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8),
    .PARITY(uart_pkg::PARITY_EVEN), .STOP_BITS(1)
  ) dut_a (
    .clock(clock), .resetn(resetn), .enable(enable), .rx(rx_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_frame_err(fe_a), .out_parity_err(pe_a), .overrun(ovr_a),
    .overrun_clr(clr_a), .break_det(brk_a), .busy(busy_a)
  );

  uart_rx_cfg #(
    .CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(7),
    .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(2)
  ) dut_b (
    .clock(clock), .resetn(resetn), .enable(enable), .rx(rx_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_frame_err(fe_b), .out_parity_err(pe_b), .overrun(ovr_b),
    .overrun_clr(clr_b), .break_det(brk_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Accepted words as {parity_err, frame_err, data}, and break pulse counts.
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  int brk_cnt_a = 0;
  int brk_cnt_b = 0;

  always @(negedge clock) begin
    if (valid_a && ready_a) qa.push_back({pe_a, fe_a, data_a});
    if (valid_b && ready_b) qb.push_back({pe_b, fe_b, 1'b0, data_b});
    if (brk_a) brk_cnt_a++;
    if (brk_b) brk_cnt_b++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives bits[0] first, one bit period each, then returns the line to idle.
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx_a = bits[i];
      else rx_b = bits[i];
      tick(TPB);
    end
    if (which == 0) rx_a = 1'b1;
    else rx_b = 1'b1;
  endtask

  task automatic frame_a(input logic [7:0] d, input logic p, input logic stop);
    send_bits(0, {5'd0, stop, p, d, 1'b0}, 11);
  endtask

  task automatic frame_b(input logic [6:0] d, input logic s1, input logic s2);
    send_bits(1, {6'd0, s2, s1, d, 1'b0}, 10);
  endtask

  // Reference: even parity means data ones plus parity bit must total an even count.
  function automatic logic [9:0] model_a(input logic [7:0] d, input logic p, input logic stop);
    int   ones;
    logic pe;
    ones = $countones(d) + int'(p);
    pe   = (ones % 2) != 0;
    return {pe, ~stop, d};
  endfunction

  function automatic logic [9:0] model_b(input logic [6:0] d, input logic s1, input logic s2);
    return {1'b0, ~(s1 & s2), 1'b0, d};
  endfunction

  // Waits (bounded) for exactly one accepted word and compares it.
  task automatic expect_word(input int which, input string tag, input logic [9:0] exp);
    int         waited;
    int         n;
    logic [9:0] got;
    waited = 0;
    n = (which == 0) ? qa.size() : qb.size();
    while (n == 0 && waited < 4 * TPB) begin
      tick(1);
      waited++;
      n = (which == 0) ? qa.size() : qb.size();
    end
    check({tag, "_count"}, 32'(n), 32'd1);
    if (n > 0) begin
      if (which == 0) got = qa.pop_front();
      else got = qb.pop_front();
      check(tag, {22'd0, got}, {22'd0, exp});
    end
    if (which == 0) qa.delete();
    else qb.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] d7;
    logic       p, s, s1, s2;
    int         exp_brk, brk0;

    rx_a = 1'b1; rx_b = 1'b1; enable = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    resetn = 1'b0;
    tick(3);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_data_a", data_a, 8'h00);
    check("rst_flags_a", {fe_a, pe_a, ovr_a, brk_a}, 4'h0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_valid_b", valid_b, 1'b0);
    resetn = 1'b1;
    tick(4);

    // Clean word with correct parity.
    frame_a(8'hA5, 1'b0, 1'b1);
    expect_word(0, "t1_a5", model_a(8'hA5, 1'b0, 1'b1));
    check("t1_busy", busy_a, 1'b0);
    tick(8);

    // Randomized frames on dut_a, including bad parity and bad stop bits.
    exp_brk = 0;
    brk0 = brk_cnt_a;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      if (d == 8'h00 && !s) exp_brk++;
      frame_a(d, p, s);
      expect_word(0, "rand_a", model_a(d, p, s));
      tick(6 + int'($urandom_range(0, 4)));
    end
    check("rand_a_breaks", brk_cnt_a - brk0, exp_brk);

    // Parity error, then framing error without break.
    brk0 = brk_cnt_a;
    frame_a(8'hA5, 1'b1, 1'b1);
    expect_word(0, "t2_parity", model_a(8'hA5, 1'b1, 1'b1));
    tick(8);
    frame_a(8'h3C, 1'b0, 1'b0);
    expect_word(0, "t2_frame", model_a(8'h3C, 1'b0, 1'b0));
    tick(TPB);
    check("t2_no_break", brk_cnt_a - brk0, 0);

    // Glitch start shorter than half a bit.
    rx_a = 1'b0;
    tick(5);
    rx_a = 1'b1;
    tick(2 * TPB);
    check("t3_no_word", qa.size(), 0);
    check("t3_idle", busy_a, 1'b0);
    frame_a(8'h5A, 1'b0, 1'b1);
    expect_word(0, "t3_5a", model_a(8'h5A, 1'b0, 1'b1));
    tick(8);

    // Overrun: second word dropped while the first waits.
    ready_a = 1'b0;
    frame_a(8'h11, 1'b0, 1'b1);
    tick(8);
    frame_a(8'h22, 1'b0, 1'b1);
    tick(8);
    check("t4_valid_held", valid_a, 1'b1);
    check("t4_data_kept", data_a, 8'h11);
    check("t4_overrun", ovr_a, 1'b1);
    ready_a = 1'b1;
    tick(1);
    check("t4_valid_drop", valid_a, 1'b0);
    expect_word(0, "t4_accept", model_a(8'h11, 1'b0, 1'b1));
    check("t4_overrun_sticky", ovr_a, 1'b1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t4_overrun_clr", ovr_a, 1'b0);

    // Line break: 15 bit times low.
    brk0 = brk_cnt_a;
    rx_a = 1'b0;
    tick(13 * TPB);
    check("t5_wait_busy", busy_a, 1'b1);
    tick(2 * TPB);
    rx_a = 1'b1;
    tick(8);
    expect_word(0, "t5_break_word", {1'b0, 1'b1, 8'h00});
    check("t5_break_pulses", brk_cnt_a - brk0, 1);
    frame_a(8'h7E, 1'b0, 1'b1);
    expect_word(0, "t5_7e", model_a(8'h7E, 1'b0, 1'b1));
    tick(8);

    // Enable dropped mid-frame aborts it.
    send_bits(0, 16'hFFFE, 3);
    enable = 1'b0;
    tick(2);
    check("en_abort_idle", busy_a, 1'b0);
    enable = 1'b1;
    tick(3 * TPB);
    check("en_abort_no_word", qa.size(), 0);

    // Reset during DATA of 0xFF.
    rx_a = 1'b0;
    tick(TPB);
    rx_a = 1'b1;
    tick(3 * TPB);
    resetn = 1'b0;
    tick(1);
    check("t6_rst_valid", valid_a, 1'b0);
    check("t6_rst_data", data_a, 8'h00);
    check("t6_rst_busy", busy_a, 1'b0);
    tick(2);
    resetn = 1'b1;
    tick(4);
    frame_a(8'h81, 1'b0, 1'b1);
    expect_word(0, "t6_81", model_a(8'h81, 1'b0, 1'b1));
    tick(8);

    // dut_b: 7 data bits, no parity, 2 stop bits.
    frame_b(7'h55, 1'b1, 1'b1);
    expect_word(1, "b_55", model_b(7'h55, 1'b1, 1'b1));
    tick(8);
    exp_brk = 0;
    brk0 = brk_cnt_b;
    for (int i = 0; i < 6; i++) begin
      d7 = 7'($urandom_range(0, 127));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      if (d7 == 7'h00 && !s2) exp_brk++;
      frame_b(d7, s1, s2);
      expect_word(1, "rand_b", model_b(d7, s1, s2));
      tick(6 + int'($urandom_range(0, 4)));
    end
    check("rand_b_breaks", brk_cnt_b - brk0, exp_brk);

    rx_b = 1'b0;
    tick(TPB);
    rx_b = 1'b1;
    tick(3 * TPB);
    resetn = 1'b0;
    tick(1);
    check("b_rst_valid", valid_b, 1'b0);
    check("b_rst_data", data_b, 7'h00);
    check("b_rst_busy", busy_b, 1'b0);
    tick(2);
    resetn = 1'b1;
    tick(4);
    frame_b(7'h55, 1'b1, 1'b1);
    expect_word(1, "b_55_after_rst", model_b(7'h55, 1'b1, 1'b1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
